gmii_rx_deframer: RTL and testbench
===================================

Name: gmii_rx_deframer

Overview:
- Receive-side stage directly downstream of the RGMII PHY pins, after the DDR input capture has produced single-rate GMII bytes.
- Strips preamble and SFD, and removes the 4-byte FCS after checking its CRC-32.
- Streams the payload as an AXI-stream-style byte stream with no backpressure.
- Flags bad frames on the last beat and raises per-frame status pulses.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal length in bytes after SFD (FCS included).
- MAX_FRAME_LEN, 1518, maximum legal length in bytes after SFD (FCS included).

Ports:
- clk  input  1  receive clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gmii_rxd  input  8  receive byte.
- gmii_rx_dv  input  1  data valid.
- gmii_rx_er  input  1  receive error.
- m_axis_tdata  output  8  payload byte.
- m_axis_tvalid  output  1  beat valid; there is no tready, so the consumer must always accept.
- m_axis_tlast  output  1  last payload byte of the frame.
- m_axis_tuser  output  1  frame bad; meaningful only when tlast=1.
- rx_frame_good  output  1  one-cycle pulse, coincident with the tlast of a good frame.
- rx_frame_bad  output  1  one-cycle pulse for a bad frame, including runts that produced no beats.
- rx_bad_fcs  output  1  one-cycle pulse, coincident with rx_frame_bad, when the CRC check failed.
- stat_frames_good, stat_frames_bad, stat_fcs_err  output  32 each  counters; see Optional Feature.

Behaviour:
- Reset: every output clears to 0, the FSM goes to IDLE, and the delay line and CRC are cleared. Reset is asynchronous, so this applies mid-frame too.
- GMII inputs are registered once before any use.
- FSM states: IDLE, PREAMBLE, PAYLOAD, WAIT_END.
- IDLE:
  - dv=1 with byte 0x55 -> PREAMBLE.
  - dv=1 with byte 0xD5 -> PAYLOAD (short preamble accepted).
  - dv=1 with any other byte -> WAIT_END.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> PAYLOAD.
  - Any other byte -> WAIT_END.
  - dv=0 -> IDLE.
  - Nothing is emitted and no status is raised in any of these cases.
- PAYLOAD: each byte goes into an 11-bit length counter that saturates at 2047, the CRC, and a 5-byte delay line.
  - Once the delay line holds 5 bytes, each new byte pushes the oldest one out as a beat with tlast=0.
  - The first cycle with dv=0 ends the frame. The oldest delay-line byte is emitted with tlast=1, and the remaining 4 bytes (the FCS) are discarded. Then -> IDLE.
- Latency: fixed 7 clk cycles from a byte on gmii_rxd to its beat on m_axis, for every beat including tlast.
- tuser=1 on the tlast beat if any of the following holds:
  - CRC residue mismatch;
  - gmii_rx_er was seen during PAYLOAD;
  - length < MIN_FRAME_LEN.
- CRC-32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, computed over every byte after the SFD including the FCS. The frame passes only if the final register equals 0xDEBB20E3.
- Runt (dv drops with 5 or fewer bytes after SFD): no beats are emitted. rx_frame_bad pulses at the cycle where tlast would have appeared. rx_bad_fcs is not asserted.
- Oversize: when length reaches MAX_FRAME_LEN+1, the current oldest byte is emitted with tlast=1 and tuser=1, rx_frame_bad pulses, the delay line is flushed, and the FSM goes to WAIT_END.
- WAIT_END: ignores all input until dv=0, then -> IDLE.
- Frame spacing: back-to-back frames separated by a single dv=0 cycle must be received correctly. The tail of frame N and the head of frame N+1 never collide, because the preamble is at least 1 byte.
- After reset release with dv already 1, the FSM goes to WAIT_END. A frame is never picked up mid-stream.
- m_axis_tvalid is never asserted for preamble, SFD, FCS or idle bytes.

Optional Feature:
- Macro: GMII_RX_DEFRAMER_STATS_EN.
- Defined: three 32-bit counters that saturate at 0xFFFFFFFF and increment on rx_frame_good, rx_frame_bad and rx_bad_fcs respectively. They are cleared only by reset.
- Undefined: the counter logic is absent and the stat_* ports are tied to 0. All other behaviour is identical.

Test Plan:
- 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS -> 60 beats in order, tlast on 0x3B, tuser=0, rx_frame_good one pulse, first beat 7 cycles after first payload byte.
- Same frame with 1 payload bit flipped -> 60 beats, tuser=1, rx_frame_bad and rx_bad_fcs pulse, stat_fcs_err=1 when macro defined.
- Preamble then SFD then 4 bytes and dv low -> zero beats, rx_frame_bad pulse, rx_bad_fcs=0.
- 1600-byte frame -> beat count 1514, last one tlast=1 with tuser=1, then input ignored until dv low; next good frame received normally.
- Two good 64-byte frames separated by one dv=0 cycle, one with gmii_rx_er pulsed mid-payload -> first tuser=0, second tuser=1, each exactly 60 beats.
- rst_n asserted mid-payload, released while dv=1 -> all outputs 0 immediately, remainder of that frame emits nothing, following frame received good.

Source files
------------

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks and removes the FCS, streams payload bytes.
// Optional statistics counters are built only when GMII_RX_DEFRAMER_STATS_EN is defined.
module gmii_rx_deframer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        rx_frame_good,
  output logic        rx_frame_bad,
  output logic        rx_bad_fcs,
  output logic [31:0] stat_frames_good,
  output logic [31:0] stat_frames_bad,
  output logic [31:0] stat_fcs_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_WAIT_END = 2'd3
  } state_t;

  localparam logic [7:0]  LP_PRE     = 8'h55;
  localparam logic [7:0]  LP_SFD     = 8'hD5;
  localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] LP_CRC_INIT = 32'hFFFFFFFF;
  localparam logic [10:0] LP_LEN_SAT = 11'h7FF;
  localparam logic [10:0] LP_FULL    = 11'd5;
  localparam logic [10:0] LP_MIN     = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LP_MAX_P1  = 11'(MAX_FRAME_LEN + 1);

  // Reflected CRC-32 (0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [7:0]      r_rxd;
  logic            r_dv;
  logic            r_er;
  logic            r_primed;
  logic            r_armed;
  state_t          r_state;
  logic [10:0]     r_len;
  logic [31:0]     r_crc;
  logic            r_err;
  logic [4:0][7:0] r_dl;
  logic [7:0]      r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_tuser;
  logic            r_good;
  logic            r_bad;
  logic            r_bad_fcs;

  state_t          w_state_nxt;
  logic [10:0]     w_len_nxt;
  logic [10:0]     w_len_inc;
  logic [31:0]     w_crc_nxt;
  logic            w_err_nxt;
  logic [4:0][7:0] w_dl_nxt;
  logic [7:0]      w_tdata_nxt;
  logic            w_tvalid_nxt;
  logic            w_tlast_nxt;
  logic            w_tuser_nxt;
  logic            w_good_nxt;
  logic            w_bad_nxt;
  logic            w_fcs_nxt;
  logic            w_crc_bad;
  logic            w_frame_bad;

  assign w_len_inc   = (r_len == LP_LEN_SAT) ? r_len : (r_len + 11'd1);
  assign w_crc_bad   = (r_crc != LP_RESIDUE);
  assign w_frame_bad = w_crc_bad | r_err | (r_len < LP_MIN);

  // Input capture; r_armed means the previous genuine sample had dv low, so a new frame may start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd    <= 8'h00;
      r_dv     <= 1'b0;
      r_er     <= 1'b0;
      r_primed <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_rxd    <= gmii_rxd;
      r_dv     <= gmii_rx_dv;
      r_er     <= gmii_rx_er;
      r_primed <= 1'b1;
      r_armed  <= r_primed & ~r_dv;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, datapath updates and next output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_crc_nxt    = r_crc;
    w_err_nxt    = r_err;
    w_dl_nxt     = r_dl;
    w_tdata_nxt  = 8'h00;
    w_tvalid_nxt = 1'b0;
    w_tlast_nxt  = 1'b0;
    w_tuser_nxt  = 1'b0;
    w_good_nxt   = 1'b0;
    w_bad_nxt    = 1'b0;
    w_fcs_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_dv) begin
          if (!r_armed) begin
            w_state_nxt = S_WAIT_END;
          end else if (r_rxd == LP_PRE) begin
            w_state_nxt = S_PREAMBLE;
          end else if (r_rxd == LP_SFD) begin
            w_state_nxt = S_PAYLOAD;
            w_len_nxt   = 11'd0;
            w_crc_nxt   = LP_CRC_INIT;
            w_err_nxt   = 1'b0;
            w_dl_nxt    = '0;
          end else begin
            w_state_nxt = S_WAIT_END;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (!r_dv) begin
          w_state_nxt = S_IDLE;
        end else if (r_rxd == LP_PRE) begin
          w_state_nxt = S_PREAMBLE;
        end else if (r_rxd == LP_SFD) begin
          w_state_nxt = S_PAYLOAD;
          w_len_nxt   = 11'd0;
          w_crc_nxt   = LP_CRC_INIT;
          w_err_nxt   = 1'b0;
          w_dl_nxt    = '0;
        end else begin
          w_state_nxt = S_WAIT_END;
        end
      end
      S_PAYLOAD: begin
        if (r_dv) begin
          w_len_nxt = w_len_inc;
          w_crc_nxt = crc32_byte(r_crc, r_rxd);
          w_err_nxt = r_err | r_er;
          w_dl_nxt  = {r_dl[3:0], r_rxd};
          if (r_len >= LP_FULL) begin
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = r_dl[4];
          end else begin
            w_tvalid_nxt = 1'b0;
          end
          // Oversize: close the frame on the byte being pushed out and drop the rest.
          if (w_len_inc == LP_MAX_P1) begin
            w_tlast_nxt = 1'b1;
            w_tuser_nxt = 1'b1;
            w_bad_nxt   = 1'b1;
            w_len_nxt   = 11'd0;
            w_dl_nxt    = '0;
            w_state_nxt = S_WAIT_END;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
          if (r_len > LP_FULL) begin
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = r_dl[4];
            w_tlast_nxt  = 1'b1;
            w_tuser_nxt  = w_frame_bad;
            w_good_nxt   = ~w_frame_bad;
            w_bad_nxt    = w_frame_bad;
            w_fcs_nxt    = w_crc_bad;
          end else begin
            w_bad_nxt = 1'b1;
          end
        end
      end
      S_WAIT_END: begin
        if (!r_dv) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_END;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= 11'd0;
      r_crc     <= 32'h0;
      r_err     <= 1'b0;
      r_dl      <= '0;
      r_tdata   <= 8'h00;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      r_bad_fcs <= 1'b0;
    end else begin
      r_len     <= w_len_nxt;
      r_crc     <= w_crc_nxt;
      r_err     <= w_err_nxt;
      r_dl      <= w_dl_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_tlast   <= w_tlast_nxt;
      r_tuser   <= w_tuser_nxt;
      r_good    <= w_good_nxt;
      r_bad     <= w_bad_nxt;
      r_bad_fcs <= w_fcs_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign rx_frame_good = r_good;
  assign rx_frame_bad  = r_bad;
  assign rx_bad_fcs    = r_bad_fcs;

`ifdef GMII_RX_DEFRAMER_STATS_EN
  logic [31:0] r_stat_good;
  logic [31:0] r_stat_bad;
  logic [31:0] r_stat_fcs;

  // Saturating frame statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_good <= 32'h0;
      r_stat_bad  <= 32'h0;
      r_stat_fcs  <= 32'h0;
    end else begin
      if (r_good && (r_stat_good != 32'hFFFFFFFF)) begin
        r_stat_good <= r_stat_good + 32'd1;
      end else begin
        r_stat_good <= r_stat_good;
      end
      if (r_bad && (r_stat_bad != 32'hFFFFFFFF)) begin
        r_stat_bad <= r_stat_bad + 32'd1;
      end else begin
        r_stat_bad <= r_stat_bad;
      end
      if (r_bad_fcs && (r_stat_fcs != 32'hFFFFFFFF)) begin
        r_stat_fcs <= r_stat_fcs + 32'd1;
      end else begin
        r_stat_fcs <= r_stat_fcs;
      end
    end
  end

  assign stat_frames_good = r_stat_good;
  assign stat_frames_bad  = r_stat_bad;
  assign stat_fcs_err     = r_stat_fcs;
`else
  assign stat_frames_good = 32'h0;
  assign stat_frames_bad  = 32'h0;
  assign stat_fcs_err     = 32'h0;
`endif

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: good/bad/runt/oversize/back-to-back frames and mid-frame reset.
module tb_gmii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        rx_frame_good;
  logic        rx_frame_bad;
  logic        rx_bad_fcs;
  logic [31:0] stat_frames_good;
  logic [31:0] stat_frames_bad;
  logic [31:0] stat_fcs_err;

  gmii_rx_deframer #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .rx_frame_good(rx_frame_good), .rx_frame_bad(rx_frame_bad),
    .rx_bad_fcs(rx_bad_fcs), .stat_frames_good(stat_frames_good), .stat_frames_bad(stat_frames_bad),
    .stat_fcs_err(stat_fcs_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_first = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  int         lq[$];
  int         uq[$];
  int         m_beats = 0;
  int         n_good = 0;
  int         n_bad = 0;
  int         n_fcs = 0;
  int         n_misalign = 0;
  int         first_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid) begin
        if (m_beats == 0) first_cyc = cyc;
        mq.push_back(m_axis_tdata);
        if (m_axis_tlast) begin
          lq.push_back(m_beats);
          uq.push_back(int'(m_axis_tuser));
        end
        m_beats++;
      end
      if (rx_frame_good) n_good++;
      if (rx_frame_bad) n_bad++;
      if (rx_bad_fcs) n_fcs++;
      if (rx_frame_good && !(m_axis_tvalid && m_axis_tlast)) n_misalign++;
      if (rx_bad_fcs && !rx_frame_bad) n_misalign++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Post-SFD bytes 0,1,2,... plus an optional correct FCS (LSB first).
  task automatic build(input int n, input bit add_fcs);
    logic [31:0] c;
    logic [31:0] fcs;
    tx_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(i[7:0]);
      c = crc_ref(c, i[7:0]);
    end
    if (add_fcs) begin
      fcs = ~c;
      tx_q.push_back(fcs[7:0]);
      tx_q.push_back(fcs[15:8]);
      tx_q.push_back(fcs[23:16]);
      tx_q.push_back(fcs[31:24]);
    end
  endtask

  task automatic exp_payload(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i[7:0]);
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int npre, input int er_at);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < tx_q.size(); i++) begin
      drive(1'b1, (i == er_at), tx_q[i]);
      if (i == 0) t_first = cyc;
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr_mon();
    mq.delete();
    lq.delete();
    uq.delete();
    exp_q.delete();
    m_beats = 0;
    n_good = 0;
    n_bad = 0;
    n_fcs = 0;
    n_misalign = 0;
    first_cyc = -1;
  endtask

  task automatic chk_data(input string tag);
    int mism;
    mism = (mq.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < mq.size(); i++) begin
      if (i >= exp_q.size() || mq[i] !== exp_q[i]) mism++;
    end
    chk(tag, mism, 0);
  endtask

  function automatic int last_idx(input int k);
    return (lq.size() > k) ? lq[k] : -1;
  endfunction

  function automatic int last_user(input int k);
    return (uq.size() > k) ? uq[k] : 2;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                          rx_frame_good, rx_frame_bad, rx_bad_fcs}, 32'd0);
    chk("reset_stats", stat_frames_good | stat_frames_bad | stat_fcs_err, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Good 64-byte frame
    clr_mon();
    build(60, 1'b1);
    exp_payload(60);
    send_frame(7, -1);
    idle(12);
    chk("t1_beats", m_beats, 60);
    chk_data("t1_data");
    chk("t1_nlast", lq.size(), 1);
    chk("t1_last_idx", last_idx(0), 59);
    chk("t1_tuser", last_user(0), 0);
    chk("t1_good", n_good, 1);
    chk("t1_bad", n_bad, 0);
    chk("t1_latency", first_cyc - t_first, 7);
    chk("t1_align", n_misalign, 0);

    // Bit flipped in payload
    clr_mon();
    build(60, 1'b1);
    tx_q[10] = tx_q[10] ^ 8'h01;
    exp_payload(60);
    exp_q[10] = exp_q[10] ^ 8'h01;
    send_frame(7, -1);
    idle(12);
    chk("t2_beats", m_beats, 60);
    chk_data("t2_data");
    chk("t2_tuser", last_user(0), 1);
    chk("t2_good", n_good, 0);
    chk("t2_bad", n_bad, 1);
    chk("t2_fcs", n_fcs, 1);
    chk("t2_align", n_misalign, 0);
`ifdef GMII_RX_DEFRAMER_STATS_EN
    chk("t2_stat_fcs", stat_fcs_err, 32'd1);
`else
    chk("t2_stat_fcs", stat_fcs_err, 32'd0);
`endif

    // Runt: 4 bytes after SFD
    clr_mon();
    build(4, 1'b0);
    send_frame(7, -1);
    idle(12);
    chk("t3_beats", m_beats, 0);
    chk("t3_bad", n_bad, 1);
    chk("t3_fcs", n_fcs, 0);
    chk("t3_good", n_good, 0);

    // Oversize 1600-byte frame
    clr_mon();
    build(1600, 1'b0);
    exp_payload(1514);
    send_frame(7, -1);
    idle(12);
    chk("t4_beats", m_beats, 1514);
    chk_data("t4_data");
    chk("t4_nlast", lq.size(), 1);
    chk("t4_last_idx", last_idx(0), 1513);
    chk("t4_tuser", last_user(0), 1);
    chk("t4_bad", n_bad, 1);
    chk("t4_fcs", n_fcs, 0);
    chk("t4_good", n_good, 0);

    // Good frame after oversize
    clr_mon();
    build(60, 1'b1);
    exp_payload(60);
    send_frame(7, -1);
    idle(12);
    chk("t4b_beats", m_beats, 60);
    chk_data("t4b_data");
    chk("t4b_good", n_good, 1);
    chk("t4b_tuser", last_user(0), 0);

    // Back-to-back frames, one idle cycle, second with rx_er mid-payload
    clr_mon();
    build(60, 1'b1);
    exp_payload(60);
    exp_payload(60);
    send_frame(7, -1);
    send_frame(7, 20);
    idle(12);
    chk("t5_beats", m_beats, 120);
    chk_data("t5_data");
    chk("t5_nlast", lq.size(), 2);
    chk("t5_last0", last_idx(0), 59);
    chk("t5_last1", last_idx(1), 119);
    chk("t5_user0", last_user(0), 0);
    chk("t5_user1", last_user(1), 1);
    chk("t5_good", n_good, 1);
    chk("t5_bad", n_bad, 1);
    chk("t5_fcs", n_fcs, 0);
`ifdef GMII_RX_DEFRAMER_STATS_EN
    chk("t5_stat_good", stat_frames_good, 32'd3);
    chk("t5_stat_bad", stat_frames_bad, 32'd4);
    chk("t5_stat_fcs", stat_fcs_err, 32'd1);
`else
    chk("t5_stat_zero", stat_frames_good | stat_frames_bad | stat_fcs_err, 32'd0);
`endif

    // Reset asserted mid-payload, released while dv=1
    clr_mon();
    build(60, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, tx_q[i]);
    #2;
    chk("t6_pre_valid", m_axis_tvalid, 1);
    chk("t6_pre_data", m_axis_tdata, 8'h16);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                           rx_frame_good, rx_frame_bad, rx_bad_fcs}, 32'd0);
    chk("t6_rst_stats", stat_frames_good | stat_frames_bad | stat_fcs_err, 32'd0);
    clr_mon();
    for (int i = 30; i < 33; i++) drive(1'b1, 1'b0, tx_q[i]);
    #2;
    rst_n = 1'b1;
    for (int i = 33; i < 64; i++) drive(1'b1, 1'b0, tx_q[i]);
    drive(1'b0, 1'b0, 8'h00);
    idle(12);
    chk("t6_rest_beats", m_beats, 0);
    chk("t6_rest_status", n_good + n_bad + n_fcs, 0);

    clr_mon();
    build(60, 1'b1);
    exp_payload(60);
    send_frame(7, -1);
    idle(12);
    chk("t6_next_beats", m_beats, 60);
    chk_data("t6_next_data");
    chk("t6_next_good", n_good, 1);
    chk("t6_next_tuser", last_user(0), 0);
`ifdef GMII_RX_DEFRAMER_STATS_EN
    chk("t6_stat_good", stat_frames_good, 32'd1);
`else
    chk("t6_stat_good", stat_frames_good, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
